// File: rtl/x_pll_ctrl_if.sv
// x_pll_ctrl_if -- PLL control bundle between the controller and its user.
//
// Signals
//   i_lock        PLL LOCK, asynchronous to the controller clock
//   i_restart     single-cycle restart request
//   o_pll_resetb  PLL RESETB (0 = PLL held in reset)
//   o_bypass      PLL BYPASS
//   o_ready       PLL output valid for use
//   o_fail        controller parked in FAIL
//   o_lost        one-cycle pulse on loss of lock while running
//   o_lost_cnt    saturating count of o_lost pulses
//   o_state       current controller state (HOLD=0 WAIT=1 STABLE=2 RUN=3 FAIL=4)
//
// Modports
//   slave   the controller (drives the o_* signals)
//   master  the user / environment (drives i_lock and i_restart)
interface x_pll_ctrl_if;
  logic       i_lock;
  logic       i_restart;
  logic       o_pll_resetb;
  logic       o_bypass;
  logic       o_ready;
  logic       o_fail;
  logic       o_lost;
  logic [7:0] o_lost_cnt;
  logic [2:0] o_state;

  modport slave (
    input  i_lock, i_restart,
    output o_pll_resetb, o_bypass, o_ready, o_fail, o_lost, o_lost_cnt, o_state
  );

  modport master (
    output i_lock, i_restart,
    input  o_pll_resetb, o_bypass, o_ready, o_fail, o_lost, o_lost_cnt, o_state
  );
endinterface

// File: rtl/x_pll_ctrl.sv
// x_pll_ctrl -- PLL power-up / lock supervision controller.
//
// Holds the PLL in reset for P_HOLD cycles, waits up to P_TIMEOUT cycles for
// lock, requires P_LOCK consecutive synchronized lock cycles before declaring
// the output ready, and watches for lock loss while running.
//
// Ports
//   i_clk  reference clock, all state updates on its rising edge
//   i_rst  asynchronous active-high reset
//   pll    x_pll_ctrl_if.slave bundle (lock/restart in, PLL controls and
//          status out); every output is a flop, no input reaches an output
//          combinationally.
//
// Configuration macro
//   X_PLL_CTRL_RETRY_EN  defined: timeout and lock loss retry from HOLD, FAIL
//                        is unreachable and o_fail is tied 0.
//                        undefined: timeout and lock loss park in FAIL until
//                        i_restart.
module x_pll_ctrl #(
  parameter int unsigned P_HOLD    = 16,
  parameter int unsigned P_LOCK    = 1024,
  parameter int unsigned P_TIMEOUT = 60000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  x_pll_ctrl_if.slave pll
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(P_HOLD - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(P_LOCK - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(P_TIMEOUT - 1);

  // Where a timeout or a lock loss sends the controller.
`ifdef X_PLL_CTRL_RETRY_EN
  localparam state_t ST_GIVE_UP = ST_HOLD;
`else
  localparam state_t ST_GIVE_UP = ST_FAIL;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lock_meta_q, lock_s_q;
  logic        resetb_q, resetb_d;
  logic        bypass_q, bypass_d;
  logic        ready_q, ready_d;
  logic        lost_q, lost_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;

  // Two-flop synchronizer for the asynchronous LOCK input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll.i_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    lost_d     = 1'b0;
    lost_cnt_d = lost_cnt_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s_q)                   state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_GIVE_UP;
      end
      ST_STABLE: begin
        // The counter restarts on entry, so it counts consecutive good cycles.
        if (!lock_s_q)               state_d = ST_WAIT;
        else if (cnt_q == LOCK_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          lost_d  = 1'b1;
          state_d = ST_GIVE_UP;
          if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Restart overrides the transition but not the lost pulse/count above.
    if (pll.i_restart) state_d = ST_HOLD;

    // Cleared on every state entry, including HOLD re-entered from HOLD.
    if (state_d != state_q || pll.i_restart) cnt_d = '0;
    else                                     cnt_d = cnt_q + 16'd1;

    // Outputs decoded from the next state so they line up with o_state.
    resetb_d = (state_d == ST_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    bypass_d = (state_d != ST_RUN);
    ready_d  = (state_d == ST_RUN);
  end

  // Reset values make o_ready/o_pll_resetb drop the moment i_rst rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      resetb_q   <= 1'b0;
      bypass_q   <= 1'b1;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resetb_q   <= resetb_d;
      bypass_q   <= bypass_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

`ifdef X_PLL_CTRL_RETRY_EN
  assign pll.o_fail = 1'b0;
`else
  logic fail_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) fail_q <= 1'b0;
    else       fail_q <= (state_d == ST_FAIL);
  end

  assign pll.o_fail = fail_q;
`endif

  assign pll.o_pll_resetb = resetb_q;
  assign pll.o_bypass     = bypass_q;
  assign pll.o_ready      = ready_q;
  assign pll.o_lost       = lost_q;
  assign pll.o_lost_cnt   = lost_cnt_q;
  assign pll.o_state      = state_q;

endmodule
